// File: rtl/profile_gen_multi.sv
// Multi-axis jerk-limited profile generator: per-channel x/v/a/j integrated one channel per clock,
// with step/dir pulses on every change of integer position and a 32-bit half-word parameter bus.
module profile_gen_multi #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CH_BITS  = 3,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned FRAC     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 acc_step,
    input  logic [CH_BITS+1:0]   param_addr,
    input  logic [31:0]          param_in,
    input  logic                 param_write_lo,
    input  logic                 param_write_hi,
    input  logic                 param_rd_hi,
    output logic [31:0]          param_out,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [CHANNELS-1:0]  step,
    output logic [CHANNELS-1:0]  dir,
    output logic [CHANNELS-1:0]  step_err,
    input  logic                 err_clear
);
    localparam int unsigned IW = WIDTH - FRAC;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [CH_BITS-1:0]   ch_q, ch_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic [CHANNELS-1:0]  step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic [31:0]          rd_q, rd_d;

    // Register file indexed [channel][reg], reg 0=x 1=v 2=a 3=j.
    logic [WIDTH-1:0]     regs_q [CHANNELS][4];
    logic [WIDTH-1:0]     regs_d [CHANNELS][4];

    logic [CH_BITS-1:0]   addr_ch;
    logic [1:0]           addr_reg;
    logic                 addr_ok;
    logic [WIDTH-1:0]     x_new;
    logic [IW-1:0]        dpos;
    logic signed [WIDTH-1:0] rd_val;
    logic signed [63:0]   rd_ext;

    assign addr_ch  = param_addr[CH_BITS+1:2];
    assign addr_reg = param_addr[1:0];
    assign addr_ok  = 32'(addr_ch) < CHANNELS;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        done_d    = 1'b0;
        overrun_d = overrun_q & ~err_clear;
        if (acc_step && state_q == StRun) overrun_d = 1'b1;
        case (state_q)
            StIdle: begin
                if (acc_step) begin
                    state_d = StRun;
                    ch_d    = '0;
                end
            end
            StRun: begin
                ch_d = ch_q + 1'b1;
                if (ch_q == CH_BITS'(CHANNELS - 1)) begin
                    state_d = StIdle;
                    ch_d    = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        step_d = '0;
        dir_d  = dir_q;
        err_d  = err_q & ~{CHANNELS{err_clear}};
        x_new  = '0;
        dpos   = '0;
        if (state_q == StRun) begin
            x_new = regs_q[ch_q][0] + regs_q[ch_q][1];
            dpos  = x_new[WIDTH-1:FRAC] - regs_q[ch_q][0][WIDTH-1:FRAC];
            regs_d[ch_q][0] = x_new;
            regs_d[ch_q][1] = regs_q[ch_q][1] + regs_q[ch_q][2];
            regs_d[ch_q][2] = regs_q[ch_q][2] + regs_q[ch_q][3];
            if (dpos != '0) begin
                step_d[ch_q] = 1'b1;
                dir_d[ch_q]  = ~dpos[IW-1];
                if (dpos != IW'(1) && dpos != '1) err_d[ch_q] = 1'b1;
            end
        end
        // Bus writes land after the update so unwritten halves keep the integrated value.
        if (addr_ok) begin
            if (param_write_lo) regs_d[addr_ch][addr_reg][31:0] = param_in;
            if (param_write_hi) regs_d[addr_ch][addr_reg][WIDTH-1:32] = param_in[WIDTH-33:0];
        end
    end

    always_comb begin
        rd_val = addr_ok ? regs_q[addr_ch][addr_reg] : '0;
        rd_ext = 64'(rd_val);
        rd_d   = param_rd_hi ? rd_ext[63:32] : rd_ext[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            step_q    <= '0;
            dir_q     <= '0;
            err_q     <= '0;
            rd_q      <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                for (int r = 0; r < 4; r++) regs_q[c][r] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            regs_q    <= regs_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign step      = step_q;
    assign dir       = dir_q;
    assign step_err  = err_q;
    assign param_out = rd_q;

endmodule

// File: tb/tb_profile_gen_multi.sv
// Directed bench for profile_gen_multi (8 channels, 64-bit state, 32 fractional bits).
module tb_profile_gen_multi;
    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acc_step;
    logic [4:0]    param_addr;
    logic [31:0]   param_in;
    logic          param_write_lo;
    logic          param_write_hi;
    logic          param_rd_hi;
    logic [31:0]   param_out;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [CH-1:0] step;
    logic [CH-1:0] dir;
    logic [CH-1:0] step_err;
    logic          err_clear;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int step_cnt [CH];

    profile_gen_multi #(
        .CHANNELS(CH),
        .CH_BITS (3),
        .WIDTH   (64),
        .FRAC    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .acc_step      (acc_step),
        .param_addr    (param_addr),
        .param_in      (param_in),
        .param_write_lo(param_write_lo),
        .param_write_hi(param_write_hi),
        .param_rd_hi   (param_rd_hi),
        .param_out     (param_out),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .step          (step),
        .dir           (dir),
        .step_err      (step_err),
        .err_clear     (err_clear)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_half(input int c, input int r, input logic [31:0] d, input logic hi);
        param_addr     = {3'(c), 2'(r)};
        param_in       = d;
        param_write_lo = ~hi;
        param_write_hi = hi;
        tick();
        param_write_lo = 1'b0;
        param_write_hi = 1'b0;
    endtask

    task automatic write64(input int c, input int r, input logic [63:0] v);
        write_half(c, r, v[31:0], 1'b0);
        write_half(c, r, v[63:32], 1'b1);
    endtask

    task automatic read_half(input int c, input int r, input logic hi, output logic [31:0] d);
        param_addr  = {3'(c), 2'(r)};
        param_rd_hi = hi;
        tick();
        d = param_out;
    endtask

    // Runs one pass; collects busy cycles, per-channel step pulses and the done sample index.
    task automatic run_pass;
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 0; c < CH; c++) step_cnt[c] = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            for (int c = 0; c < CH; c++) if (step[c]) step_cnt[c]++;
            if (done) begin
                done_cnt++;
                done_at = i;
                break;
            end
            tick();
        end
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL pass_timeout: no done within 20 cycles");
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0; acc_step = 1'b0; param_addr = '0; param_in = '0;
        param_write_lo = 1'b0; param_write_hi = 1'b0; param_rd_hi = 1'b0; err_clear = 1'b0;
        #3;
        checks++;
        if ({busy, done, overrun} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, overrun});
        end
        checks++;
        if ({step, dir, step_err, param_out} !== 56'h0) begin
            errors++;
            $display("FAIL reset_outs: step=%h dir=%h err=%h out=%h want 0", step, dir, step_err,
                     param_out);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        read_half(5, 1, 1'b0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_reg: got %h want 0", d); end
    endtask

    task automatic test_unit_velocity;
        logic [31:0] lo, hi;
        write64(0, 1, 64'h1_0000_0000);
        run_pass();
        checks++;
        if (busy_cnt !== 8 || done_at !== 8) begin
            errors++; $display("FAIL ch0_timing: busy=%0d done_at=%0d want 8/8", busy_cnt, done_at);
        end
        checks++;
        if (step_cnt[0] !== 1 || dir[0] !== 1'b1) begin
            errors++; $display("FAIL ch0_step: steps=%0d dir=%b want 1/1", step_cnt[0], dir[0]);
        end
        read_half(0, 0, 1'b0, lo);
        read_half(0, 0, 1'b1, hi);
        checks++;
        if (lo !== 32'h0 || hi !== 32'h1) begin
            errors++; $display("FAIL ch0_x: got %h_%h want 00000001_00000000", hi, lo);
        end
    endtask

    task automatic test_negative;
        logic [31:0] lo, hi;
        write64(1, 1, 64'hFFFF_FFFF_8000_0000);
        run_pass();
        checks++;
        if (step_cnt[1] !== 1 || dir[1] !== 1'b0) begin
            errors++; $display("FAIL ch1_pass1: steps=%0d dir=%b want 1/0", step_cnt[1], dir[1]);
        end
        run_pass();
        checks++;
        if (step_cnt[1] !== 0 || dir[1] !== 1'b0) begin
            errors++; $display("FAIL ch1_pass2: steps=%0d dir=%b want 0/0", step_cnt[1], dir[1]);
        end
        read_half(1, 0, 1'b0, lo);
        read_half(1, 0, 1'b1, hi);
        checks++;
        if (lo !== 32'h0 || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL ch1_x: got %h_%h want ffffffff_00000000", hi, lo);
        end
    endtask

    task automatic test_accel;
        logic [31:0] xlo, xhi, vlo, vhi;
        write64(2, 2, 64'h0000_0000_4000_0000);
        for (int p = 0; p < 4; p++) begin
            run_pass();
            checks++;
            if (step_cnt[2] !== ((p == 3) ? 1 : 0)) begin
                errors++; $display("FAIL ch2_step_pass%0d: got %0d", p, step_cnt[2]);
            end
        end
        checks++;
        if (dir[2] !== 1'b1) begin errors++; $display("FAIL ch2_dir: got %b want 1", dir[2]); end
        read_half(2, 0, 1'b0, xlo);
        read_half(2, 0, 1'b1, xhi);
        read_half(2, 1, 1'b0, vlo);
        read_half(2, 1, 1'b1, vhi);
        checks++;
        if ({xhi, xlo} !== 64'h1_8000_0000 || {vhi, vlo} !== 64'h1_0000_0000) begin
            errors++; $display("FAIL ch2_xv: x=%h_%h v=%h_%h want x=1.5 v=1.0", xhi, xlo, vhi, vlo);
        end
    endtask

    task automatic test_jerk;
        logic [31:0] lo, hi;
        write64(3, 3, 64'h1_0000_0000);
        for (int p = 0; p < 3; p++) run_pass();
        read_half(3, 2, 1'b1, hi);
        read_half(3, 2, 1'b0, lo);
        checks++;
        if ({hi, lo} !== 64'h3_0000_0000) begin
            errors++; $display("FAIL ch3_a: got %h_%h want 3.0", hi, lo);
        end
        read_half(3, 0, 1'b1, hi);
        checks++;
        if (hi !== 32'h1 || step_err[3] !== 1'b0) begin
            errors++; $display("FAIL ch3_x_err: xhi=%h err=%b want 1/0", hi, step_err[3]);
        end
        write64(3, 1, 64'h3_0000_0000);
        run_pass();
        checks++;
        if (step_err[3] !== 1'b1 || step_cnt[3] !== 1) begin
            errors++; $display("FAIL ch3_jump: err=%b steps=%0d want 1/1", step_err[3], step_cnt[3]);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (step_err[3] !== 1'b0) begin errors++; $display("FAIL ch3_clear: got 1 want 0"); end
    endtask

    task automatic test_overrun;
        int dones = 0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got 1 want 0"); end
        acc_step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dones++;
            if (i == 8) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    errors++; $display("FAIL ovr_end1: busy=%b done=%b want 0/1", busy, done);
                end
            end
        end
        acc_step = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ovr_restart: busy=0 want 1"); end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        checks++;
        if (dones !== 2 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_count: dones=%0d ovr=%b want 2/1", dones, overrun);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got 1 want 0"); end
    endtask

    task automatic test_mid_reset;
        logic [31:0] xhi, vhi;
        int dones = 0;
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || step !== '0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst: busy=%b step=%h done=%b want 0", busy, step, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) dones++;
        end
        read_half(0, 0, 1'b1, xhi);
        read_half(0, 1, 1'b1, vhi);
        checks++;
        if (dones !== 0 || xhi !== 32'h0 || vhi !== 32'h0 || dir !== '0) begin
            errors++;
            $display("FAIL midrst_regs: dones=%0d xhi=%h vhi=%h dir=%h want 0", dones, xhi, vhi, dir);
        end
    endtask

    task automatic test_collision;
        logic [31:0] xlo, xhi, vlo, vhi;
        write64(4, 1, 64'h1_0000_0001);
        // Pass 1: lo-only write to x on the edge ch4 is integrated.
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        repeat (4) tick();
        param_addr = {3'd4, 2'd0}; param_in = 32'hDEAD_BEEF; param_write_lo = 1'b1;
        tick();
        param_write_lo = 1'b0;
        repeat (6) tick();
        read_half(4, 0, 1'b0, xlo);
        read_half(4, 0, 1'b1, xhi);
        checks++;
        if ({xhi, xlo} !== 64'h1_DEAD_BEEF) begin
            errors++; $display("FAIL coll_lo: got %h_%h want 00000001_deadbeef", xhi, xlo);
        end
        // Pass 2: full lo+hi write to v on the ch4 update edge.
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        repeat (4) tick();
        param_addr = {3'd4, 2'd1}; param_in = 32'h0000_0002;
        param_write_lo = 1'b1; param_write_hi = 1'b1;
        tick();
        param_write_lo = 1'b0; param_write_hi = 1'b0;
        repeat (6) tick();
        read_half(4, 1, 1'b0, vlo);
        read_half(4, 1, 1'b1, vhi);
        read_half(4, 0, 1'b0, xlo);
        read_half(4, 0, 1'b1, xhi);
        checks++;
        if ({vhi, vlo} !== 64'h2_0000_0002) begin
            errors++; $display("FAIL coll_full_v: got %h_%h want 00000002_00000002", vhi, vlo);
        end
        checks++;
        if ({xhi, xlo} !== 64'h2_DEAD_BEF0) begin
            errors++; $display("FAIL coll_x2: got %h_%h want 00000002_deadbef0", xhi, xlo);
        end
    endtask

    initial begin
        test_reset();
        test_unit_velocity();
        test_negative();
        test_accel();
        test_jerk();
        test_overrun();
        test_mid_reset();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
